// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit.
//   - csr_op_e    : funct3[1:0] operation encodings (00 is illegal)
//   - CSR_IMM_BIT : funct3 bit selecting the zero-extended uimm source
//   - csr_state_e : access FSM states
//   - csr_is_ro() : true for read-only CSR addresses (addr[11:10] == 2'b11)
package csr_pkg;

   typedef enum logic [1:0] {
      CSR_ILL = 2'b00,
      CSR_RW  = 2'b01,
      CSR_RS  = 2'b10,
      CSR_RC  = 2'b11
   } csr_op_e;

   localparam int unsigned CSR_IMM_BIT = 2;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      WRITE,
      DONE,
      TRAP
   } csr_state_e;

   function automatic logic csr_is_ro(input logic [11:0] addr);
      return addr[11:10] == 2'b11;
   endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// Combinational read-modify-write datapath for Zicsr operations.
//   op     : operation (RW / RS / RC)
//   old    : current CSR value
//   src    : rs1 value or zero-extended uimm
//   result : value to be stored back
module csr_alu
   import csr_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  csr_op_e          op,
   input  logic [XLEN-1:0]  old,
   input  logic [XLEN-1:0]  src,
   output logic [XLEN-1:0]  result
);

   always_comb begin
      result = '0;
      unique case (op)
         CSR_RW:  result = src;
         CSR_RS:  result = old | src;
         CSR_RC:  result = old & ~src;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR load/store interface. Executes Zicsr
// instructions from the execute stage: reads the CSR, performs the
// read-modify-write, issues the store and returns the old value for rd
// (or flags an illegal instruction).
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_valid / o_ready       : execute-stage handshake
//   i_funct3, i_csr, i_rs1_idx, i_rs1_val, i_rd : instruction fields
//   o_ld_csr, o_ld, i_rdata, i_trap             : CSR file load side
//   o_st_csr, o_st, o_wdata                     : CSR file store side
//   o_done, o_illegal, o_rd_we, o_rd, o_rd_data : completion report
module csr_access_unit
   import csr_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_funct3,
   input  logic [11:0]      i_csr,
   input  logic [4:0]       i_rs1_idx,
   input  logic [XLEN-1:0]  i_rs1_val,
   input  logic [4:0]       i_rd,
   output logic [11:0]      o_ld_csr,
   output logic [11:0]      o_st_csr,
   output logic             o_ld,
   output logic             o_st,
   output logic [XLEN-1:0]  o_wdata,
   input  logic [XLEN-1:0]  i_rdata,
   input  logic             i_trap,
   output logic             o_done,
   output logic             o_illegal,
   output logic             o_rd_we,
   output logic [4:0]       o_rd,
   output logic [XLEN-1:0]  o_rd_data
);

   csr_state_e       state_q, state_d;
   logic [2:0]       funct3_q;
   logic [11:0]      csr_q;
   logic [4:0]       rs1_idx_q;
   logic [XLEN-1:0]  rs1_val_q;
   logic [4:0]       rd_q;
   logic [XLEN-1:0]  old_q;
   logic [XLEN-1:0]  wdata_q;
   logic [11:0]      st_csr_q;

   csr_op_e          op;
   logic             ill_f3;
   logic [XLEN-1:0]  src;
   logic             rd_en;
   logic             wr_en;
   logic             ro_fault;
   logic [XLEN-1:0]  cap_old;
   logic [XLEN-1:0]  new_val;

   // Decode from the latched instruction fields.
   assign op       = csr_op_e'(funct3_q[1:0]);
   assign ill_f3   = (op == CSR_ILL);
   assign src      = funct3_q[CSR_IMM_BIT] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
   assign rd_en    = (op != CSR_RW) || (rd_q != 5'd0);
   assign wr_en    = (op == CSR_RW) || (rs1_idx_q != 5'd0);
   assign ro_fault = wr_en && csr_is_ro(csr_q);
   // A write-only CSRRW never reads, so the old value is taken as zero.
   assign cap_old  = rd_en ? i_rdata : '0;

   csr_alu #(.XLEN(XLEN)) u_alu (
      .op     (op),
      .old    (cap_old),
      .src    (src),
      .result (new_val)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         funct3_q  <= '0;
         csr_q     <= '0;
         rs1_idx_q <= '0;
         rs1_val_q <= '0;
         rd_q      <= '0;
         old_q     <= '0;
         wdata_q   <= '0;
         st_csr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && i_valid) begin
            funct3_q  <= i_funct3;
            csr_q     <= i_csr;
            rs1_idx_q <= i_rs1_idx;
            rs1_val_q <= i_rs1_val;
            rd_q      <= i_rd;
         end
         if (state_q == CAPTURE) begin
            old_q   <= cap_old;
            wdata_q <= new_val;
            // Store address only moves when a store will follow, so it
            // keeps showing the last stored CSR while idle.
            if (wr_en) begin
               st_csr_q <= csr_q;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      o_ready   = 1'b0;
      o_ld      = 1'b0;
      o_st      = 1'b0;
      o_done    = 1'b0;
      o_illegal = 1'b0;
      o_rd_we   = 1'b0;
      unique case (state_q)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               state_d = READ;
            end
         end
         READ: begin
            o_ld = rd_en && !ill_f3;
            if (i_trap || ro_fault || ill_f3) begin
               state_d = TRAP;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: state_d = wr_en ? WRITE : DONE;
         WRITE: begin
            o_st    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            o_done  = 1'b1;
            o_rd_we = (rd_q != 5'd0) && rd_en;
            state_d = IDLE;
         end
         TRAP: begin
            o_done    = 1'b1;
            o_illegal = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_ld_csr  = csr_q;
   assign o_st_csr  = st_csr_q;
   assign o_wdata   = wdata_q;
   assign o_rd      = rd_q;
   assign o_rd_data = old_q;

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

   localparam int unsigned XLEN = 64;

   logic             clk = 1'b0;
   logic             i_reset;
   logic             i_valid;
   logic             o_ready;
   logic [2:0]       i_funct3;
   logic [11:0]      i_csr;
   logic [4:0]       i_rs1_idx;
   logic [XLEN-1:0]  i_rs1_val;
   logic [4:0]       i_rd;
   logic [11:0]      o_ld_csr;
   logic [11:0]      o_st_csr;
   logic             o_ld;
   logic             o_st;
   logic [XLEN-1:0]  o_wdata;
   logic [XLEN-1:0]  i_rdata;
   logic             i_trap;
   logic             o_done;
   logic             o_illegal;
   logic             o_rd_we;
   logic [4:0]       o_rd;
   logic [XLEN-1:0]  o_rd_data;

   always #5 clk = ~clk;

   // CSR file model: B-range addresses and debug-only 7B0/7B1 fault.
   assign i_trap = (o_ld_csr[11:8] == 4'hB) || (o_ld_csr == 12'h7B0) || (o_ld_csr == 12'h7B1);

   csr_access_unit #(.XLEN(XLEN)) dut (
      .i_clk     (clk),
      .i_reset   (i_reset),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_funct3  (i_funct3),
      .i_csr     (i_csr),
      .i_rs1_idx (i_rs1_idx),
      .i_rs1_val (i_rs1_val),
      .i_rd      (i_rd),
      .o_ld_csr  (o_ld_csr),
      .o_st_csr  (o_st_csr),
      .o_ld      (o_ld),
      .o_st      (o_st),
      .o_wdata   (o_wdata),
      .i_rdata   (i_rdata),
      .i_trap    (i_trap),
      .o_done    (o_done),
      .o_illegal (o_illegal),
      .o_rd_we   (o_rd_we),
      .o_rd      (o_rd),
      .o_rd_data (o_rd_data)
   );

   typedef struct {
      logic [2:0]      f3;
      logic [11:0]     csr;
      logic [4:0]      rs1_idx;
      logic [XLEN-1:0] rs1_val;
      logic [4:0]      rd;
      logic [XLEN-1:0] rdata;
      int unsigned     lat;
      logic            ill;
      logic            rd_we;
      logic [XLEN-1:0] rd_data;
      logic            ld;
      logic            st;
      logic [XLEN-1:0] wdata;
   } vec_t;

   vec_t        vecs[$];
   vec_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          busy = 1'b0;
   int unsigned cyc, ld_cnt, st_cnt;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1_idx,
                               input logic [XLEN-1:0] rs1_val, input logic [4:0] rd, input logic [XLEN-1:0] rdata,
                               input int unsigned lat, input logic ill, input logic rd_we,
                               input logic [XLEN-1:0] rd_data, input logic ld, input logic st,
                               input logic [XLEN-1:0] wdata);
      vec_t v;
      v.f3 = f3; v.csr = csr; v.rs1_idx = rs1_idx; v.rs1_val = rs1_val; v.rd = rd; v.rdata = rdata;
      v.lat = lat; v.ill = ill; v.rd_we = rd_we; v.rd_data = rd_data; v.ld = ld; v.st = st; v.wdata = wdata;
      return v;
   endfunction

   // Monitor / scoreboard: samples on the falling edge.
   always @(negedge clk) begin
      vec_t v;
      if (i_reset) begin
         busy = 1'b0;
         exp_q.delete();
      end else begin
         check("ld_st_exclusive", 64'(o_ld & o_st), 64'd0);
         if (busy && exp_q.size() > 0) begin
            cyc++;
            if (o_ld) begin
               ld_cnt++;
               check("ld_cycle", 64'(cyc), 64'd1);
               check("ld_csr", 64'(o_ld_csr), 64'(exp_q[0].csr));
            end
            if (o_st) begin
               st_cnt++;
               check("st_cycle", 64'(cyc), 64'd3);
               check("st_csr", 64'(o_st_csr), 64'(exp_q[0].csr));
               check("st_wdata", o_wdata, exp_q[0].wdata);
            end
            if (o_done) begin
               v = exp_q.pop_front();
               check("latency", 64'(cyc), 64'(v.lat));
               check("illegal", 64'(o_illegal), 64'(v.ill));
               check("rd_we", 64'(o_rd_we), 64'(v.rd_we));
               check("ld_count", 64'(ld_cnt), 64'(v.ld));
               check("st_count", 64'(st_cnt), 64'(v.st));
               if (v.rd_we) check("rd_idx", 64'(o_rd), 64'(v.rd));
               if (!v.ill) check("rd_data", o_rd_data, v.rd_data);
               busy = 1'b0;
            end
         end else if (o_done || o_st || o_ld) begin
            check("spurious_activity", 64'({o_done, o_st, o_ld}), 64'd0);
         end
         if (i_valid && o_ready) begin
            busy   = 1'b1;
            cyc    = 0;
            ld_cnt = 0;
            st_cnt = 0;
         end
      end
   end

   task automatic drive(input vec_t v);
      @(posedge clk); #1;
      check("ready_idle", 64'(o_ready), 64'd1);
      i_funct3  = v.f3;
      i_csr     = v.csr;
      i_rs1_idx = v.rs1_idx;
      i_rs1_val = v.rs1_val;
      i_rd      = v.rd;
      i_rdata   = v.rdata;
      i_valid   = 1'b1;
      exp_q.push_back(v);
      @(posedge clk); #1;
      i_valid   = 1'b0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 12; n++) begin
         if (!busy) break;
         @(negedge clk);
      end
      if (busy) begin
         check("done_timeout", 64'd1, 64'd0);
         busy = 1'b0;
         exp_q.delete();
      end
   endtask

   initial begin
      vec_t v;
      i_reset = 1'b1; i_valid = 1'b0; i_funct3 = '0; i_csr = '0;
      i_rs1_idx = '0; i_rs1_val = '0; i_rd = '0; i_rdata = '0;

      //    f3      csr     rs1 rs1_val                rd  rdata                  lat ill we  rd_data                ld st wdata
      vecs.push_back(mk(3'b001, 12'h340, 5'd1, 64'hDEAD_BEEF, 5'd5, 64'h1234, 4, 0, 1, 64'h1234, 1, 1, 64'hDEAD_BEEF));
      vecs.push_back(mk(3'b010, 12'h300, 5'd0, 64'h0, 5'd3, 64'h88, 3, 0, 1, 64'h88, 1, 0, 64'h0));
      vecs.push_back(mk(3'b111, 12'h300, 5'd8, 64'h0, 5'd0, 64'h88, 4, 0, 0, 64'h88, 1, 1, 64'h80));
      vecs.push_back(mk(3'b101, 12'hB00, 5'd3, 64'h0, 5'd7, 64'h0, 2, 1, 0, 64'h0, 1, 0, 64'h0));
      vecs.push_back(mk(3'b001, 12'h305, 5'd2, 64'h8000_0100, 5'd0, 64'h55, 4, 0, 0, 64'h0, 0, 1, 64'h8000_0100));
      vecs.push_back(mk(3'b100, 12'h300, 5'd1, 64'h0, 5'd1, 64'h0, 2, 1, 0, 64'h0, 0, 0, 64'h0));
      vecs.push_back(mk(3'b001, 12'hC00, 5'd1, 64'h5, 5'd4, 64'h0, 2, 1, 0, 64'h0, 1, 0, 64'h0));
      vecs.push_back(mk(3'b010, 12'hC01, 5'd0, 64'h0, 5'd9, 64'h1_0000_FFFF, 3, 0, 1, 64'h1_0000_FFFF, 1, 0, 64'h0));
      vecs.push_back(mk(3'b010, 12'h341, 5'd4, 64'hF0, 5'd2, 64'hFFFF_0000_0000_000F, 4, 0, 1,
                        64'hFFFF_0000_0000_000F, 1, 1, 64'hFFFF_0000_0000_00FF));
      vecs.push_back(mk(3'b011, 12'h342, 5'd6, 64'h8000_0000_0000_0001, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 4, 0, 1,
                        64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h7FFF_FFFF_FFFF_FFFE));
      vecs.push_back(mk(3'b110, 12'h300, 5'd0, 64'h0, 5'd0, 64'h7, 3, 0, 0, 64'h7, 1, 0, 64'h0));
      vecs.push_back(mk(3'b101, 12'h340, 5'd31, 64'h0, 5'd1, 64'hAA, 4, 0, 1, 64'hAA, 1, 1, 64'h1F));
      vecs.push_back(mk(3'b010, 12'h7B0, 5'd1, 64'h1, 5'd2, 64'h0, 2, 1, 0, 64'h0, 1, 0, 64'h0));

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_strobes", 64'({o_ld, o_st, o_done, o_illegal, o_rd_we}), 64'd0);
      check("rst_ld_csr", 64'(o_ld_csr), 64'd0);
      check("rst_st_csr", 64'(o_st_csr), 64'd0);
      check("rst_wdata", o_wdata, 64'd0);
      check("rst_rd", 64'(o_rd), 64'd0);
      check("rst_rd_data", o_rd_data, 64'd0);
      @(posedge clk); #1;
      i_reset = 1'b0;

      // Table-driven vectors, issued back to back.
      foreach (vecs[i]) begin
         drive(vecs[i]);
         wait_done();
      end

      // Addresses hold while idle.
      repeat (2) @(negedge clk);
      check("ld_csr_hold", 64'(o_ld_csr), 64'h7B0);
      check("st_csr_hold", 64'(o_st_csr), 64'h340);

      // Reset during WRITE drops the store and the completion.
      v = mk(3'b001, 12'h340, 5'd1, 64'h55, 5'd5, 64'h11, 4, 0, 1, 64'h11, 1, 1, 64'h55);
      drive(v);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (o_st) break;
      end
      check("mid_st_seen", 64'(o_st), 64'd1);
      #1 i_reset = 1'b1;
      @(negedge clk);
      check("mid_rst_st", 64'(o_st), 64'd0);
      check("mid_rst_done", 64'(o_done), 64'd0);
      check("mid_rst_ready", 64'(o_ready), 64'd1);
      @(posedge clk); #1;
      i_reset = 1'b0;
      repeat (3) @(negedge clk);

      // Normal operation resumes after the aborted access.
      drive(mk(3'b010, 12'h300, 5'd0, 64'h0, 5'd3, 64'h99, 3, 0, 1, 64'h99, 1, 0, 64'h0));
      wait_done();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
